// File: rtl/pipe_hazard_fwd_unit.sv
// pipe_hazard_fwd_unit: ID-stage forwarding, load-use stall, flush squash and event counters
module pipe_hazard_fwd_unit #(
    parameter int ASIZE    = 4,
    parameter int DSIZE    = 16,
    parameter int STAGES   = 3,
    parameter int LOAD_LAT = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [ASIZE-1:0]        id_rs,
    input  logic [ASIZE-1:0]        id_rt,
    input  logic                    id_use1,
    input  logic                    id_use2,
    input  logic                    id_wen,
    input  logic [ASIZE-1:0]        id_waddr,
    input  logic                    id_load,
    input  logic                    flush,
    input  logic [DSIZE-1:0]        rf_rdata1,
    input  logic [DSIZE-1:0]        rf_rdata2,
    input  logic [STAGES*DSIZE-1:0] fwd_data,
    output logic [DSIZE-1:0]        opa,
    output logic [DSIZE-1:0]        opb,
    output logic                    stall,
    output logic                    issue,
    output logic [STAGES:0]         fwd_sel1,
    output logic [STAGES:0]         fwd_sel2,
    output logic [15:0]             stall_cnt,
    output logic [15:0]             fwd_cnt
);
    logic [STAGES-1:0] v_q, wen_q, load_q;
    logic [ASIZE-1:0]  waddr_q [STAGES];
    logic [15:0]       stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
    logic [ASIZE-1:0]  src [2];
    logic [1:0]        use_v, haz;
    logic [STAGES:0]   sel [2];
    logic [DSIZE-1:0]  op [2];
    logic [DSIZE-1:0]  rf [2];

    assign src   = '{id_rs, id_rt};
    assign use_v = {id_use2, id_use1};
    assign rf    = '{rf_rdata1, rf_rdata2};

    // Scan oldest to youngest so the youngest match decides; an unready youngest match reads the regfile and raises a hazard
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            sel[j] = (STAGES+1)'(1) << STAGES;
            haz[j] = 1'b0;
            for (int k = STAGES-1; k >= 0; k--) begin
                if (use_v[j] && v_q[k] && wen_q[k] && waddr_q[k] == src[j] && !(ZERO_REG != 0 && src[j] == '0)) begin
                    haz[j] = load_q[k] && k < LOAD_LAT;
                    sel[j] = haz[j] ? (STAGES+1)'(1) << STAGES : (STAGES+1)'(1) << k;
                end
            end
        end
    end

    // Operand muxes driven by the one-hot selects
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            op[j] = rf[j];
            for (int k = 0; k < STAGES; k++)
                if (sel[j][k]) op[j] = fwd_data[k*DSIZE +: DSIZE];
        end
    end

    assign stall     = id_valid & ~flush & (|haz);
    assign issue     = id_valid & ~stall & ~flush;
    assign fwd_sel1  = sel[0];
    assign fwd_sel2  = sel[1];
    assign opa       = op[0];
    assign opb       = op[1];
    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

    // Saturating counter next state
    always_comb begin
        stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
        fwd_cnt_d   = (issue && (!sel[0][STAGES] || !sel[1][STAGES]) && fwd_cnt_q != 16'hFFFF) ? fwd_cnt_q + 16'd1 : fwd_cnt_q;
    end

    // Tracking shift register advances every cycle; a non-issue cycle inserts a bubble
    always_ff @(posedge clk) begin
        wen_q      <= {wen_q[STAGES-2:0], issue & id_wen};
        load_q     <= {load_q[STAGES-2:0], issue & id_load};
        waddr_q[0] <= issue ? id_waddr : '0;
        for (int k = 1; k < STAGES; k++) waddr_q[k] <= waddr_q[k-1];
        if (!rst) begin
            v_q         <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            v_q         <= {v_q[STAGES-2:0], issue};
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// tb_pipe_hazard_fwd_unit: directed scoreboard bench for the hazard/forwarding unit
module tb_pipe_hazard_fwd_unit;
    logic        clk = 1'b0, rst = 1'b0;
    logic        id_valid = 1'b0, id_use1 = 1'b0, id_use2 = 1'b0, id_wen = 1'b0, id_load = 1'b0, flush = 1'b0;
    logic [3:0]  id_rs = '0, id_rt = '0, id_waddr = '0;
    logic [15:0] rf_rdata1 = 16'h1111, rf_rdata2 = 16'h2222;
    logic [47:0] fwd_data = {16'hA002, 16'hA001, 16'hA000};
    logic [15:0] opa, opb, stall_cnt, fwd_cnt;
    logic        stall, issue;
    logic [3:0]  fwd_sel1, fwd_sel2;

    typedef struct {
        int          tag;
        logic        st, is;
        logic [3:0]  s1, s2;
        logic [15:0] a, b, sc, fc;
    } exp_t;

    exp_t        sb [$];
    int          total = 0, bad = 0, n = 0;
    logic [15:0] m_sc = '0, m_fc = '0;

    pipe_hazard_fwd_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use1(id_use1), .id_use2(id_use2), .id_wen(id_wen), .id_waddr(id_waddr),
        .id_load(id_load), .flush(flush), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_data(fwd_data), .opa(opa), .opb(opb), .stall(stall), .issue(issue),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s step %0d got=%h want=%h", nm, tag, got, want);
        end
    endtask

    // s1/s2: expected selected source index, 3 = regfile
    task automatic drive(input logic r, input logic v, input logic [3:0] rs, input logic [3:0] rt,
                         input logic u1, input logic u2, input logic we, input logic [3:0] wa,
                         input logic ld, input logic fl, input logic st, input int s1, input int s2);
        exp_t e;
        @(negedge clk);
        rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_use1 = u1; id_use2 = u2;
        id_wen = we; id_waddr = wa; id_load = ld; flush = fl;
        n++;
        e.tag = n;
        e.st  = st;
        e.is  = v & ~st & ~fl;
        e.s1  = 4'(1 << s1);
        e.s2  = 4'(1 << s2);
        e.a   = (s1 == 3) ? 16'h1111 : 16'hA000 + 16'(s1);
        e.b   = (s2 == 3) ? 16'h2222 : 16'hA000 + 16'(s2);
        e.sc  = m_sc;
        e.fc  = m_fc;
        sb.push_back(e);
        if (!r) begin
            m_sc = '0;
            m_fc = '0;
        end else begin
            if (st && m_sc != 16'hFFFF) m_sc++;
            if (e.is && (s1 != 3 || s2 != 3) && m_fc != 16'hFFFF) m_fc++;
        end
    endtask

    task automatic check();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty step %0d got=0 want=1", n);
            return;
        end
        e = sb.pop_front();
        cmp("stall", e.tag, 16'(stall), 16'(e.st));
        cmp("issue", e.tag, 16'(issue), 16'(e.is));
        cmp("fwd_sel1", e.tag, 16'(fwd_sel1), 16'(e.s1));
        cmp("fwd_sel2", e.tag, 16'(fwd_sel2), 16'(e.s2));
        cmp("opa", e.tag, opa, e.a);
        cmp("opb", e.tag, opb, e.b);
        cmp("stall_cnt", e.tag, stall_cnt, e.sc);
        cmp("fwd_cnt", e.tag, fwd_cnt, e.fc);
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] rs, input logic [3:0] rt,
                        input logic u1, input logic u2, input logic we, input logic [3:0] wa,
                        input logic ld, input logic fl, input logic st, input int s1, input int s2);
        drive(r, v, rs, rt, u1, u2, we, wa, ld, fl, st, s1, s2);
        check();
    endtask

    initial begin
        //    rst v  rs rt u1 u2 we wa ld fl  st s1 s2
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        // ADD r3 then SUB r4,r3,r1
        step(1, 1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 3, 3);
        step(1, 1, 3, 1, 1, 1, 1, 4, 0, 0, 0, 0, 3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        // LOAD r5 then ADD r6,r5,r5: two stall cycles then forward from stage 2
        step(1, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 3, 3);
        step(1, 1, 5, 5, 1, 1, 1, 6, 0, 0, 1, 3, 3);
        step(1, 1, 5, 5, 1, 1, 1, 6, 0, 0, 1, 3, 3);
        step(1, 1, 5, 5, 1, 1, 1, 6, 0, 0, 0, 2, 2);
        // r2 in flight at k=0 and k=2: youngest wins
        step(1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 3, 3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        step(1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 3, 3);
        step(1, 1, 2, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        // load r2 at k=0 with a ready copy at k=2: still stalls
        step(1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 3, 3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        step(1, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 3, 3);
        step(1, 1, 2, 7, 1, 1, 1, 9, 0, 0, 1, 3, 3);
        // flush during the stall squashes the r9 writer; it must not be forwarded
        step(1, 1, 2, 7, 1, 1, 1, 9, 0, 1, 0, 3, 3);
        step(1, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 3, 3);
        // writes to r0 are never forwarded and never stall
        step(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 3, 3);
        step(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3, 3);
        // reset during a stall
        step(1, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 3, 3);
        step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 3, 3);
        step(0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 3, 3);
        step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 3, 3);
        // stall counter saturation
        step(1, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 3, 3);
        m_sc = 16'hFFFF;
        drive(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 3, 3);
        force dut.stall_cnt_q = 16'hFFFF;
        check();
        release dut.stall_cnt_q;
        step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 3, 3);
        step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 2, 3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
